iir_cascade_sequencer: RTL and testbench

Time-multiplexed controller for a cascade of first-order IIR sections. It uses one shared fixed-point multiplier instead of three per section. It owns the coefficient register file, with a write/read config port addressed like the coefficient RAM map, and the per-section delay state (x1, y1). It sequences each accepted sample through all sections and returns the result over a valid/ready handshake.

---
 rtl/iir_cascade_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_iir_cascade_sequencer.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_cascade_sequencer.sv
// Cascade of first-order IIR sections sharing one fixed-point multiplier.
// Holds the coefficient file and per-section (x1, y1) history; samples enter/leave via valid/ready.
module iir_cascade_sequencer #(
  parameter int NUM_SECT = 3,
  parameter int DW       = 16,
  parameter int FRAC     = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_we,
  input  logic [7:0]    cfg_addr,
  input  logic [DW-1:0] cfg_wdata,
  output logic [DW-1:0] cfg_rdata,
  output logic          cfg_err,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          busy
);

  localparam int KW      = (NUM_SECT > 1) ? $clog2(NUM_SECT) : 1;
  localparam int B1_BASE = 16;

  typedef enum logic [2:0] {IDLE, MUL0, MUL1, MUL2, UPD, DONE} state_t;

  state_t state_reg, state_next;

  logic [DW-1:0] a0_arr [NUM_SECT];
  logic [DW-1:0] a1_arr [NUM_SECT];
  logic [DW-1:0] b1_arr [NUM_SECT];
  logic [DW-1:0] x1_arr [NUM_SECT];
  logic [DW-1:0] y1_arr [NUM_SECT];

  logic [DW-1:0]   cur_reg;
  logic [DW-1:0]   acc_reg;
  logic [DW-1:0]   out_data_reg;
  logic [KW-1:0]   k_reg;
  logic            out_valid_reg;
  logic            cfg_err_reg;
  logic            in_ready_reg;

  logic            accept;
  logic            last_sect;
  logic            cfg_ok;
  logic            addr_mapped;
  logic [DW-1:0]   mul_a;
  logic [DW-1:0]   mul_b;
  logic [2*DW-1:0] prod_full;
  logic [DW-1:0]   prod_slice;
  logic            prod_unused;

  assign accept    = in_valid & in_ready_reg;
  assign last_sect = (k_reg == KW'(NUM_SECT - 1));
  assign cfg_ok    = cfg_we & (state_reg == IDLE);

  // Per-section coefficient and history registers.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SECT; gi++) begin : g_sect
      localparam logic [7:0] A0_ADDR = 8'(2 * gi);
      localparam logic [7:0] A1_ADDR = 8'(2 * gi + 1);
      localparam logic [7:0] B1_ADDR = 8'(B1_BASE + gi);

      logic [DW-1:0] a0_reg, a1_reg, b1_reg, x1_reg, y1_reg;
      logic          hist_en;

      assign hist_en = (state_reg == UPD) && (k_reg == KW'(gi));

      always_ff @(posedge clk) begin
        if (!reset) begin
          a0_reg <= '0;
          a1_reg <= '0;
          b1_reg <= '0;
          x1_reg <= '0;
          y1_reg <= '0;
        end else begin
          if (cfg_ok && (cfg_addr == A0_ADDR)) a0_reg <= cfg_wdata;
          if (cfg_ok && (cfg_addr == A1_ADDR)) a1_reg <= cfg_wdata;
          if (cfg_ok && (cfg_addr == B1_ADDR)) b1_reg <= cfg_wdata;
          if (hist_en) begin
            x1_reg <= cur_reg;
            y1_reg <= acc_reg;
          end
        end
      end

      assign a0_arr[gi] = a0_reg;
      assign a1_arr[gi] = a1_reg;
      assign b1_arr[gi] = b1_reg;
      assign x1_arr[gi] = x1_reg;
      assign y1_arr[gi] = y1_reg;
    end
  endgenerate

  always_comb begin
    cfg_rdata   = '0;
    addr_mapped = 1'b0;
    for (int i = 0; i < NUM_SECT; i++) begin
      if (cfg_addr == 8'(2 * i)) begin
        cfg_rdata   = a0_arr[i];
        addr_mapped = 1'b1;
      end
      if (cfg_addr == 8'(2 * i + 1)) begin
        cfg_rdata   = a1_arr[i];
        addr_mapped = 1'b1;
      end
      if (cfg_addr == 8'(B1_BASE + i)) begin
        cfg_rdata   = b1_arr[i];
        addr_mapped = 1'b1;
      end
    end
  end

  // The single shared multiplier; operands are selected by the current phase.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_reg)
      MUL0: begin
        mul_a = a0_arr[k_reg];
        mul_b = cur_reg;
      end
      MUL1: begin
        mul_a = a1_arr[k_reg];
        mul_b = x1_arr[k_reg];
      end
      MUL2: begin
        mul_a = b1_arr[k_reg];
        mul_b = y1_arr[k_reg];
      end
      default: begin
        mul_a = '0;
        mul_b = '0;
      end
    endcase
  end

  assign prod_full   = {{DW{1'b0}}, mul_a} * {{DW{1'b0}}, mul_b};
  assign prod_slice  = prod_full[FRAC+DW-1:FRAC];
  assign prod_unused = ^{prod_full[2*DW-1:FRAC+DW], prod_full[FRAC-1:0]};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = MUL0;
      MUL0:    state_next = MUL1;
      MUL1:    state_next = MUL2;
      MUL2:    state_next = UPD;
      UPD:     state_next = last_sect ? DONE : MUL0;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= IDLE;
      in_ready_reg <= 1'b0;
      cfg_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= (state_next == IDLE);
      cfg_err_reg  <= cfg_we & ~(cfg_ok & addr_mapped);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_reg       <= '0;
      acc_reg       <= '0;
      k_reg         <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            cur_reg <= in_data;
            k_reg   <= '0;
          end
        end
        MUL0: acc_reg <= prod_slice;
        MUL1: acc_reg <= acc_reg + prod_slice;
        MUL2: acc_reg <= acc_reg - prod_slice;
        UPD: begin
          cur_reg <= acc_reg;
          if (last_sect) begin
            out_data_reg  <= acc_reg;
            out_valid_reg <= 1'b1;
          end else begin
            k_reg <= k_reg + KW'(1);
          end
        end
        DONE: begin
          if (out_ready) out_valid_reg <= 1'b0;
        end
        default: begin
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign cfg_err   = cfg_err_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_iir_cascade_sequencer.sv
// Bench for iir_cascade_sequencer: directed scenarios plus randomized samples
// checked against a plain-arithmetic cascade model.
module tb_iir_cascade_sequencer;

  localparam int NS = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_we = 1'b0;
  logic [7:0]  cfg_addr = 8'h00;
  logic [15:0] cfg_wdata = 16'h0000;
  logic [15:0] cfg_rdata;
  logic        cfg_err;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'h0000;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        busy;

  int total = 0;
  int bad   = 0;

  int a0m [NS];
  int a1m [NS];
  int b1m [NS];
  int x1m [NS];
  int y1m [NS];

  always #5 clk = ~clk;

  iir_cascade_sequencer #(.NUM_SECT(NS), .DW(16), .FRAC(11)) dut (
    .clk(clk), .reset(reset),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  // ---------------- reference model ----------------
  function automatic int pm(int a, int b);
    longint pr;
    pr = longint'(a) * longint'(b);
    return int'((pr >> 11) & 64'hFFFF);
  endfunction

  function automatic int model_step(int x);
    int c, y;
    c = x & 16'hFFFF;
    for (int k = 0; k < NS; k++) begin
      y = (pm(a0m[k], c) + pm(a1m[k], x1m[k]) - pm(b1m[k], y1m[k])) & 16'hFFFF;
      x1m[k] = c;
      y1m[k] = y;
      c = y;
    end
    return c;
  endfunction

  function automatic bit is_mapped(int addr);
    return (addr >= 0 && addr < 2 * NS) || (addr >= 16 && addr < 16 + NS);
  endfunction

  function automatic int model_read(int addr);
    if (addr >= 0 && addr < 2 * NS) return (addr % 2 == 0) ? a0m[addr / 2] : a1m[addr / 2];
    if (addr >= 16 && addr < 16 + NS) return b1m[addr - 16];
    return 0;
  endfunction

  function automatic void model_write(int addr, int data);
    if (addr >= 0 && addr < 2 * NS) begin
      if (addr % 2 == 0) a0m[addr / 2] = data & 16'hFFFF;
      else a1m[addr / 2] = data & 16'hFFFF;
    end else if (addr >= 16 && addr < 16 + NS) begin
      b1m[addr - 16] = data & 16'hFFFF;
    end
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < NS; k++) begin
      a0m[k] = 0; a1m[k] = 0; b1m[k] = 0; x1m[k] = 0; y1m[k] = 0;
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    model_clear();
  endtask

  task automatic cfg_write(input int addr, input int data, output logic err);
    cfg_addr = addr[7:0]; cfg_wdata = data[15:0]; cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    err = cfg_err;
  endtask

  task automatic program_sect(input int k, input int a0, input int a1, input int b1);
    logic e0, e1, e2;
    cfg_write(2 * k, a0, e0);     model_write(2 * k, a0);
    cfg_write(2 * k + 1, a1, e1); model_write(2 * k + 1, a1);
    cfg_write(16 + k, b1, e2);    model_write(16 + k, b1);
    total++;
    if ({e0, e1, e2} !== 3'b000) begin
      bad++;
      $display("FAIL cfg_accept_err sect=%0d got=%b want=000", k, {e0, e1, e2});
    end
  endtask

  task automatic send_sample(input int x, input int hold, output int got, output int lat);
    int guard;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 50) begin tick(); guard++; end
    if (guard >= 50) begin
      total++; bad++;
      $display("FAIL in_ready_timeout got=%b want=1", in_ready);
    end
    in_data = x[15:0]; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin tick(); lat++; end
    if (lat >= 200) begin
      total++; bad++;
      $display("FAIL out_valid_timeout got=%b want=1", out_valid);
    end
    got = int'(out_data);
    repeat (hold) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    total++;
    if ({out_valid, cfg_err, busy, in_ready} !== 4'b0000 || out_data !== 16'h0) begin
      bad++;
      $display("FAIL reset_outputs got v=%b e=%b b=%b r=%b d=%h want all 0", out_valid, cfg_err, busy, in_ready, out_data);
    end
    reset = 1'b1;
    tick();
    model_clear();
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release got in_ready=%b busy=%b want 1 0", in_ready, busy);
    end
    cfg_addr = 8'h10; #1;
    total++;
    if (cfg_rdata !== 16'h0) begin
      bad++;
      $display("FAIL reset_coef got=%h want=0000", cfg_rdata);
    end
    $display("reset: outputs idle, in_ready=%b", in_ready);
  endtask

  task automatic test_passthrough();
    int got, lat, exp;
    for (int k = 0; k < NS; k++) program_sect(k, 16'h0800, 0, 0);
    send_sample(16'h1234, 0, got, lat);
    exp = model_step(16'h1234);
    total++;
    if (got !== 16'h1234) begin bad++; $display("FAIL passthrough_data got=%h want=1234", got); end
    total++;
    if (lat !== 4 * NS) begin bad++; $display("FAIL passthrough_latency got=%0d want=%0d", lat, 4 * NS); end
    $display("passthrough: in=1234 out=%h model=%h latency=%0d", got, exp, lat);
  endtask

  task automatic test_gain();
    int got, lat, exp;
    for (int k = 0; k < NS; k++) program_sect(k, 16'h0400, 0, 0);
    send_sample(16'h1000, 0, got, lat);
    exp = model_step(16'h1000);
    total++;
    if (got !== 16'h0200) begin bad++; $display("FAIL gain_data got=%h want=0200", got); end
    $display("gain: in=1000 out=%h model=%h", got, exp);
  endtask

  task automatic test_history();
    int got, lat, exp;
    do_reset();
    program_sect(0, 16'h0800, 16'h0800, 0);
    for (int k = 1; k < NS; k++) program_sect(k, 16'h0800, 0, 0);
    send_sample(16'h0100, 1, got, lat);
    exp = model_step(16'h0100);
    total++;
    if (got !== 16'h0100) begin bad++; $display("FAIL history_first got=%h want=0100", got); end
    $display("history: in=0100 out=%h model=%h", got, exp);
    send_sample(16'h0200, 0, got, lat);
    exp = model_step(16'h0200);
    total++;
    if (got !== 16'h0300) begin bad++; $display("FAIL history_second got=%h want=0300", got); end
    $display("history: in=0200 out=%h model=%h", got, exp);
  endtask

  task automatic test_feedback();
    int got, lat, exp;
    do_reset();
    program_sect(0, 16'h0800, 0, 16'h0400);
    for (int k = 1; k < NS; k++) program_sect(k, 16'h0800, 0, 0);
    send_sample(16'h0400, 0, got, lat);
    exp = model_step(16'h0400);
    total++;
    if (got !== 16'h0400) begin bad++; $display("FAIL feedback_first got=%h want=0400", got); end
    $display("feedback: in=0400 out=%h model=%h", got, exp);
    send_sample(16'h0000, 0, got, lat);
    exp = model_step(16'h0000);
    total++;
    if (got !== 16'hFE00) begin bad++; $display("FAIL feedback_wrap got=%h want=fe00", got); end
    $display("feedback: in=0000 out=%h model=%h", got, exp);
  endtask

  task automatic test_backpressure();
    int guard, exp;
    logic [15:0] held;
    in_data = 16'h0321; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    exp = model_step(16'h0321);
    guard = 0;
    while (out_valid !== 1'b1 && guard < 200) begin tick(); guard++; end
    total++;
    if (out_valid !== 1'b1 || out_data !== exp[15:0]) begin
      bad++;
      $display("FAIL bp_data got v=%b d=%h want v=1 d=%h", out_valid, out_data, exp[15:0]);
    end
    held = out_data;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin cfg_addr = 8'h10; cfg_wdata = 16'h1111; cfg_we = 1'b1; end
      tick();
      cfg_we = 1'b0;
      total++;
      if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL bp_hold cyc=%0d got v=%b d=%h r=%b b=%b want v=1 d=%h r=0 b=1", i, out_valid, out_data, in_ready, busy, held);
      end
      if (i == 3 || i == 4) begin
        total++;
        if (cfg_err !== (i == 3)) begin
          bad++;
          $display("FAIL bp_cfg_err cyc=%0d got=%b want=%b", i, cfg_err, (i == 3));
        end
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release got v=%b b=%b r=%b want 0 0 1", out_valid, busy, in_ready);
    end
    cfg_addr = 8'h10; #1;
    total++;
    if (cfg_rdata !== 16'(model_read(16))) begin
      bad++;
      $display("FAIL bp_coef_kept got=%h want=%h", cfg_rdata, 16'(model_read(16)));
    end
    $display("backpressure: held=%h coef16=%h", held, cfg_rdata);
  endtask

  task automatic test_cfg_guard();
    int addrs [4];
    int data;
    logic e;
    addrs[0] = 2 * NS; addrs[1] = 16 + NS; addrs[2] = 1; addrs[3] = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      data = int'($urandom_range(16'hFFFF, 1));
      cfg_write(addrs[i], data, e);
      if (is_mapped(addrs[i])) model_write(addrs[i], data);
      total++;
      if (e !== !is_mapped(addrs[i])) begin
        bad++;
        $display("FAIL cfg_guard_err addr=%h got=%b want=%b", addrs[i], e, !is_mapped(addrs[i]));
      end
      cfg_addr = addrs[i][7:0]; #1;
      total++;
      if (cfg_rdata !== 16'(model_read(addrs[i]))) begin
        bad++;
        $display("FAIL cfg_guard_read addr=%h got=%h want=%h", addrs[i], cfg_rdata, 16'(model_read(addrs[i])));
      end
      $display("cfg: addr=%h wdata=%h err=%b rdata=%h", addrs[i], data, e, cfg_rdata);
    end
  endtask

  task automatic test_random();
    int got, lat, exp, x, hold;
    for (int k = 0; k < NS; k++)
      program_sect(k, int'($urandom_range(16'h0FFF)), int'($urandom_range(16'h07FF)), int'($urandom_range(16'h03FF)));
    for (int n = 0; n < 16; n++) begin
      x = int'($urandom_range(16'hFFFF));
      hold = int'($urandom_range(3));
      send_sample(x, hold, got, lat);
      exp = model_step(x);
      total++;
      if (got !== exp || lat !== 4 * NS) begin
        bad++;
        $display("FAIL random_sample n=%0d in=%h got=%h lat=%0d want=%h lat=%0d", n, x, got, lat, exp, 4 * NS);
      end
      $display("random: n=%0d in=%h out=%h hold=%0d", n, x, got, hold);
    end
  endtask

  task automatic test_back_to_back();
    int exp_q [$];
    int last_cyc, cyc, seen, e;
    last_cyc = -1; seen = 0;
    out_ready = 1'b1;
    in_data = 16'($urandom);
    in_valid = 1'b1;
    for (cyc = 0; cyc < 120; cyc++) begin
      if (cyc == 80) in_valid = 1'b0;
      if (in_valid && in_ready === 1'b1) exp_q.push_back(model_step(int'(in_data)));
      tick();
      if (in_valid && busy === 1'b1 && in_ready === 1'b0) in_data = 16'($urandom);
      if (out_valid === 1'b1) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        total++;
        if (int'(out_data) !== e) begin
          bad++;
          $display("FAIL b2b_data cyc=%0d got=%h want=%h", cyc, out_data, e);
        end
        if (last_cyc >= 0) begin
          total++;
          if (cyc - last_cyc !== 4 * NS + 2) begin
            bad++;
            $display("FAIL b2b_interval got=%0d want=%0d", cyc - last_cyc, 4 * NS + 2);
          end
        end
        $display("b2b: cyc=%0d out=%h", cyc, out_data);
        last_cyc = cyc; seen++;
      end
    end
    out_ready = 1'b0;
    total++;
    if (exp_q.size() !== 0 || seen < 5) begin
      bad++;
      $display("FAIL b2b_count got pending=%0d seen=%0d want pending=0 seen>=5", exp_q.size(), seen);
    end
  endtask

  task automatic test_reset_mid();
    int got, lat, spurious;
    for (int k = 0; k < NS; k++) program_sect(k, 16'h0800, 0, 0);
    in_data = 16'h5A5A; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b want=1", busy); end
    reset = 1'b0;
    tick();
    total++;
    if ({out_valid, cfg_err, busy, in_ready} !== 4'b0000 || out_data !== 16'h0) begin
      bad++;
      $display("FAIL mid_reset_outputs got v=%b e=%b b=%b r=%b d=%h want all 0", out_valid, cfg_err, busy, in_ready, out_data);
    end
    for (int a = 0; a < 32; a++) begin
      if (is_mapped(a)) begin
        cfg_addr = 8'(a); #1;
        total++;
        if (cfg_rdata !== 16'h0) begin
          bad++;
          $display("FAIL mid_coef_clear addr=%h got=%h want=0000", a, cfg_rdata);
        end
      end
    end
    reset = 1'b1;
    model_clear();
    spurious = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid === 1'b1) spurious++;
    end
    total++;
    if (spurious !== 0) begin bad++; $display("FAIL mid_aborted got=%0d outputs want=0", spurious); end
    send_sample(16'h1234, 0, got, lat);
    total++;
    if (got !== 0 || got !== model_step(16'h1234)) begin
      bad++;
      $display("FAIL mid_after_reset got=%h want=0000", got);
    end
    $display("reset_mid: aborted, next out=%h", got);
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_gain();
    test_history();
    test_feedback();
    test_backpressure();
    test_cfg_guard();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
